// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the serializer path: FSM state encoding and the
// default word length that the downstream shift register also uses.
package piso_serializer_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/piso_serializer_bit_down_counter.sv
// Bits-remaining counter: loads N, decrements on enable down to zero and
// flags the final bit (count == 1).
module bit_down_counter #(
  parameter int N = 8,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] count_r;

  // count register; load wins over decrement and zero is sticky
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= CW'(N);
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign last  = (count_r == CW'(1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a word on READY/LOAD and emits it one
// bit per TICK on SER, pulsing DONE once the final bit period has ended.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MSB_FIRST = 1,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] DIN,
  output logic             READY,
  output logic             BUSY,
  output logic             SER,
  output logic             DONE,
  output logic [CW-1:0]    BIT_CNT
);

  state_e           state_r;
  state_e           state_s;
  logic [WIDTH-1:0] shift_r;
  logic             done_r;
  logic             load_s;
  logic             shift_s;
  logic             done_set_s;
  logic             last_s;

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; a tick seen while idle is deliberately ignored
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (LOAD) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (TICK && last_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output decode: load strobe, shift strobe and completion strobe
  always_comb begin
    load_s     = 1'b0;
    shift_s    = 1'b0;
    done_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        load_s = LOAD;
      end
      ST_SHIFT: begin
        shift_s    = TICK;
        done_set_s = TICK & last_s;
      end
      default: begin
        load_s = 1'b0;
      end
    endcase
  end

  // Shift register; zero fill means the final shift leaves it cleared, so
  // SER returns to 0 in IDLE without a separate clear path.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      shift_r <= '0;
    end else if (load_s) begin
      shift_r <= DIN;
    end else if (shift_s) begin
      if (MSB_FIRST != 0) begin
        shift_r <= {shift_r[WIDTH-2:0], 1'b0};
      end else begin
        shift_r <= {1'b0, shift_r[WIDTH-1:1]};
      end
    end else begin
      shift_r <= shift_r;
    end
  end

  // one-cycle completion pulse
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      done_r <= 1'b0;
    end else begin
      done_r <= done_set_s;
    end
  end

  bit_down_counter #(
    .N (WIDTH)
  ) u_bit_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .load  (load_s),
    .en    (shift_s),
    .count (BIT_CNT),
    .last  (last_s)
  );

  assign READY = (state_r == ST_IDLE);
  assign BUSY  = ~READY;
  assign SER   = (MSB_FIRST != 0) ? shift_r[WIDTH-1] : shift_r[0];
  assign DONE  = done_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share all inputs and
// are compared every cycle against a word/bit-index reference model.
module tb_piso_serializer;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         TICK = 1'b0;
  logic         LOAD = 1'b0;
  logic [W-1:0] DIN = '0;

  logic       rdy_m, bsy_m, ser_m, done_m;
  logic [3:0] cnt_m;
  logic       rdy_l, bsy_l, ser_l, done_l;
  logic [3:0] cnt_l;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .CLK(CLK), .RST(RST), .TICK(TICK), .LOAD(LOAD), .DIN(DIN),
    .READY(rdy_m), .BUSY(bsy_m), .SER(ser_m), .DONE(done_m), .BIT_CNT(cnt_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .CLK(CLK), .RST(RST), .TICK(TICK), .LOAD(LOAD), .DIN(DIN),
    .READY(rdy_l), .BUSY(bsy_l), .SER(ser_l), .DONE(done_l), .BIT_CNT(cnt_l)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  // reference model: word in flight and how many of its bits are already sent
  logic         m_busy = 1'b0;
  logic [W-1:0] m_word = '0;
  int           m_k    = 0;
  logic         m_done = 1'b0;
  int           m_loads = 0;
  int           done_cnt = 0;
  logic [W-1:0] dn = '0;     // downstream register fed by the MSB-first SER
  logic         prev_ser = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_word = '0;
    m_k    = 0;
    m_done = 1'b0;
  endtask

  task automatic compare_all();
    logic [31:0] exp_msb, exp_lsb, exp_cnt;
    exp_msb = m_busy ? ((32'(m_word) >> (W - 1 - m_k)) & 32'd1) : 32'd0;
    exp_lsb = m_busy ? ((32'(m_word) >> m_k) & 32'd1) : 32'd0;
    exp_cnt = m_busy ? 32'(W - m_k) : 32'd0;
    check("ready_msb", 32'(rdy_m), 32'(!m_busy));
    check("busy_msb", 32'(bsy_m), 32'(m_busy));
    check("ser_msb", 32'(ser_m), exp_msb);
    check("done_msb", 32'(done_m), 32'(m_done));
    check("bitcnt_msb", 32'(cnt_m), exp_cnt);
    check("ready_lsb", 32'(rdy_l), 32'(!m_busy));
    check("ser_lsb", 32'(ser_l), exp_lsb);
    check("done_lsb", 32'(done_l), 32'(m_done));
    check("bitcnt_lsb", 32'(cnt_l), exp_cnt);
    prev_ser = ser_m;
  endtask

  // one clock: advance the model with the inputs present at the edge, then compare
  task automatic cycle();
    @(posedge CLK);
    if (!RST) begin
      model_reset();
    end else begin
      if (TICK && m_busy) dn = {dn[W-2:0], prev_ser};
      m_done = 1'b0;
      if (!m_busy) begin
        if (LOAD) begin
          m_busy = 1'b1;
          m_word = DIN;
          m_k    = 0;
          m_loads++;
        end
      end else if (TICK) begin
        if (m_k == W - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end else begin
          m_k++;
        end
      end
      if (m_done) done_cnt++;
    end
    #1;
    compare_all();
  endtask

  task automatic do_load(input logic [W-1:0] word);
    DIN  = word;
    LOAD = 1'b1;
    cycle();
    LOAD = 1'b0;
    DIN  = W'($urandom);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      TICK = 1'b1;
      cycle();
      TICK = 1'b0;
      for (int j = 1; j < gap; j++) cycle();
    end
  endtask

  initial begin
    int base;
    int gap_cycles;

    // reset held with random activity on the inputs
    #1;
    compare_all();
    for (int i = 0; i < 20; i++) begin
      LOAD = 1'($urandom);
      TICK = 1'($urandom);
      DIN  = W'($urandom);
      cycle();
    end
    check("reset_no_done", 32'(done_cnt), 32'd0);
    LOAD = 1'b0;
    TICK = 1'b0;
    RST  = 1'b1;
    cycle();

    // basic word, ticks 10 clocks apart
    dn = '0; done_cnt = 0;
    do_load(8'hA5);
    ticks(W, 10);
    cycle();
    check("a5_downstream", 32'(dn), 32'hA5);
    check("a5_done_pulses", 32'(done_cnt), 32'd1);

    // LSB-first single bit word (bit counts are checked each cycle)
    done_cnt = 0;
    do_load(8'h01);
    ticks(W, 3);
    check("01_done_pulses", 32'(done_cnt), 32'd1);

    // load request while busy must not disturb the word in flight
    dn = '0; done_cnt = 0;
    do_load(8'h0F);
    ticks(3, 4);
    DIN  = 8'hFF;
    LOAD = 1'b1;
    cycle();
    LOAD = 1'b0;
    ticks(W - 3, 4);
    check("0f_downstream", 32'(dn), 32'h0F);
    check("0f_done_pulses", 32'(done_cnt), 32'd1);

    // load coincident with tick in idle: that tick is ignored
    dn = '0;
    DIN  = 8'h5A;
    LOAD = 1'b1;
    TICK = 1'b1;
    cycle();
    LOAD = 1'b0;
    TICK = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("coincident_hold", 32'(cnt_m), 32'd8);
    end
    ticks(W, 3);
    check("5a_downstream", 32'(dn), 32'h5A);

    // back-to-back words with LOAD held high
    dn = '0; done_cnt = 0; gap_cycles = 0;
    base = m_loads;
    DIN  = 8'h3C;
    LOAD = 1'b1;
    for (int i = 0; i < 200; i++) begin
      TICK = ((i % 4) == 3);
      cycle();
      if (m_loads == base + 1) DIN = 8'hC3;
      if (m_loads == base + 1 && rdy_m === 1'b1) gap_cycles++;
      if (m_loads >= base + 2) LOAD = 1'b0;
      if (m_loads >= base + 2 && !m_busy) break;
    end
    TICK = 1'b0;
    LOAD = 1'b0;
    check("b2b_finished", 32'(m_busy), 32'd0);
    check("b2b_loads", 32'(m_loads - base), 32'd2);
    check("b2b_ready_gap", 32'(gap_cycles), 32'd1);
    check("b2b_done_pulses", 32'(done_cnt), 32'd2);
    check("b2b_downstream", 32'(dn), 32'hC3);

    // reset mid-word aborts without a DONE pulse
    done_cnt = 0;
    do_load(8'hF0);
    ticks(3, 4);
    RST = 1'b0;
    #1;
    model_reset();
    check("abort_ready", 32'(rdy_m), 32'd1);
    check("abort_ser", 32'(ser_m), 32'd0);
    check("abort_bitcnt", 32'(cnt_m), 32'd0);
    cycle();
    cycle();
    RST = 1'b1;
    cycle();
    cycle();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    dn = '0;
    do_load(8'h81);
    ticks(W, 5);
    cycle();
    check("81_downstream", 32'(dn), 32'h81);
    check("81_done_pulses", 32'(done_cnt), 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      LOAD = ($urandom_range(0, 7) == 0);
      TICK = ($urandom_range(0, 2) == 0);
      DIN  = W'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
